// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instr_mem read port and the IF/ID register with a valid/ready handshake to decode.
// Optional halt detection is compiled in with `define IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [31:0]     HALT_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        fetch_en,
  input  logic [0:31] instr,
  input  logic        br_taken,
  input  logic [0:31] br_target,
  input  logic        id_ready,
  output logic [0:31] instr_addr,
  output logic        enb,
  output logic [0:31] if_instr,
  output logic [0:31] if_pc,
  output logic        if_valid,
  output logic        halted
);

`ifdef IFU_HALT_DETECT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] if_pc_q;
  logic [PC_W-1:0] br_pc;
  logic            load;
  logic            frozen;

  // Only the low PC_W bits of the redirect target address instr_mem.
  assign br_pc = br_target[32-PC_W:31];

  assign instr_addr = {{(32-PC_W){1'b0}}, pc};
  assign if_pc      = {{(32-PC_W){1'b0}}, if_pc_q};
  assign enb        = (state == FETCH);

`ifdef IFU_HALT_DETECT_EN
  assign frozen = (state == HALTED);
  assign halted = (state == HALTED);
  logic unused_bits;
  assign unused_bits = ^br_target[0:31-PC_W];
`else
  assign frozen = 1'b0;
  assign halted = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{br_target[0:31-PC_W], HALT_WORD};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) state_next = FETCH;
      end
      FETCH: begin
        // Dropping fetch_en holds pc; a redirect suppresses the capture.
        if (!fetch_en) begin
          state_next = IDLE;
        end else if (!br_taken) begin
          load = !if_valid || id_ready;
`ifdef IFU_HALT_DETECT_EN
          if (load && (instr == HALT_WORD)) state_next = HALTED;
`endif
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE;
      pc       <= START_ADDR;
      if_instr <= '0;
      if_pc_q  <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_next;

      if (!frozen) begin
        if (br_taken)  pc <= br_pc;
        else if (load) pc <= pc + 1'b1;
      end

      if (load) begin
        if_instr <= instr;
        if_pc_q  <= pc;
      end

      // Flush on redirect wins; otherwise a load refills and a consume drains.
      if (br_taken && !frozen) if_valid <= 1'b0;
      else if (load)           if_valid <= 1'b1;
      else if (id_ready)       if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming fetch, stall, redirect, PC wrap, async reset and halt.
// Expected values are hand-computed; instr_mem is modelled as an asynchronous array.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        fetch_en;
  logic [0:31] instr;
  logic        br_taken;
  logic [0:31] br_target;
  logic        id_ready;
  logic [0:31] instr_addr;
  logic        enb;
  logic [0:31] if_instr;
  logic [0:31] if_pc;
  logic        if_valid;
  logic        halted;

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_fetch_unit #(
    .PC_W      (8),
    .START_ADDR(8'h00),
    .HALT_WORD (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .fetch_en  (fetch_en),
    .instr     (instr),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_ready  (id_ready),
    .instr_addr(instr_addr),
    .enb       (enb),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_valid  (if_valid),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign instr = mem[instr_addr[24:31]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    reset_b   = 1'b0;
    fetch_en  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    id_ready  = 1'b0;
    #12;
    check("rst_enb",      enb,        32'd0);
    check("rst_valid",    if_valid,   32'd0);
    check("rst_addr",     instr_addr, 32'd0);
    check("rst_if_instr", if_instr,   32'd0);
    check("rst_halted",   halted,     32'd0);

    // Streaming fetch: one address per cycle, data one cycle after its address.
    @(negedge clk);
    reset_b  = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    tick();
    check("t1_enb",  enb,        32'd1);
    check("t1_addr0", instr_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_if_pc%0d", k),  if_pc,      k);
      check($sformatf("t1_instr%0d", k),  if_instr,   32'h1000_0000 + k);
      check($sformatf("t1_addr%0d", k+1), instr_addr, k + 1);
      check($sformatf("t1_valid%0d", k),  if_valid,   32'd1);
    end

    // Stall with word 3 held in IF/ID.
    id_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t2_hold_instr", if_instr,   32'h1000_0003);
      check("t2_hold_addr",  instr_addr, 32'd4);
      check("t2_hold_enb",   enb,        32'd1);
    end
    id_ready = 1'b1;
    tick();
    check("t2_release_pc", if_pc,    32'd4);
    check("t2_release_in", if_instr, 32'h1000_0004);

    // Redirect during a stall flushes and retargets.
    id_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0000_0040;
    tick();
    br_taken = 1'b0;
    check("t3_flush_valid", if_valid,   32'd0);
    check("t3_br_addr",     instr_addr, 32'h40);
    tick();
    check("t3_br_if_pc", if_pc,    32'h40);
    check("t3_br_instr", if_instr, 32'h1000_0040);
    check("t3_br_valid", if_valid, 32'd1);

    // PC wrap through 2**PC_W-1.
    id_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_00FE;
    tick();
    br_taken = 1'b0;
    check("t4_flush", if_valid, 32'd0);
    tick(); check("t4_pc_fe", if_pc, 32'hFE);
    tick(); check("t4_pc_ff", if_pc, 32'hFF);
    tick(); check("t4_pc_00", if_pc, 32'h00);
            check("t4_in_00", if_instr, 32'h1000_0000);
    tick(); check("t4_pc_01", if_pc, 32'h01);

    // Asynchronous reset in the middle of a stall.
    id_ready = 1'b0;
    tick();
    check("t5_pre_valid", if_valid,   32'd1);
    check("t5_pre_addr",  instr_addr, 32'd2);
    #2;
    reset_b = 1'b0;
    #1;
    check("t5_enb",    enb,        32'd0);
    check("t5_valid",  if_valid,   32'd0);
    check("t5_halted", halted,     32'd0);
    check("t5_addr",   instr_addr, 32'd0);

    // Halt word at address 5.
    mem[5] = 32'h0000_0000;
    @(negedge clk);
    reset_b  = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("t6_if_pc5",  if_pc,    32'd5);
    check("t6_valid5",  if_valid, 32'd1);
    check("t6_instr5",  if_instr, 32'h0000_0000);
`ifdef IFU_HALT_DETECT_EN
    check("t6_halted", halted, 32'd1);
    check("t6_enb",    enb,    32'd0);
    br_taken  = 1'b1;
    br_target = 32'h0000_0020;
    tick();
    br_taken = 1'b0;
    check("t6_br_ignored", instr_addr, 32'd6);
    check("t6_drained",    if_valid,   32'd0);
    check("t6_still_halt", halted,     32'd1);
`else
    check("t6_halted", halted, 32'd0);
    check("t6_enb",    enb,    32'd1);
    tick();
    check("t6_continue_pc",    if_pc,    32'd6);
    check("t6_continue_instr", if_instr, 32'h1000_0006);
`endif

    // Dropping fetch_en returns to idle with pc held.
    fetch_en = 1'b0;
    tick();
    check("t7_idle_enb", enb, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
